// File: rtl/filter_pkg.sv
// Shared widths and arithmetic helpers for the stream filter blocks
// (row convolution, adder tree, column sum).
package filter_pkg;

    localparam int MAX_W = 64;

    function automatic int acc_width(input int img_w, input int ker_w, input int taps);
        return img_w + ker_w + $clog2(taps);
    endfunction

    function automatic int lat(input int taps);
        return 2 + $clog2(taps);
    endfunction

    // Callers size-cast operands up to MAX_W and truncate the product back down.
    function automatic logic signed [MAX_W-1:0] smul(input logic signed [MAX_W-1:0] a,
                                                     input logic signed [MAX_W-1:0] b);
        return a * b;
    endfunction

    function automatic logic signed [MAX_W-1:0] sext(input logic [MAX_W-1:0] v, input int w);
        return $signed(v << (MAX_W - w)) >>> (MAX_W - w);
    endfunction

endpackage

// File: rtl/filter_add_tree.sv
// Pipelined signed adder tree: N operands, one registered level per halving,
// all levels held at the full sum width; an odd trailing operand passes through.
module filter_add_tree #(
    parameter  int N         = 3,
    parameter  int IN_WIDTH  = 32,
    localparam int LEVELS    = $clog2(N),
    localparam int SUM_WIDTH = IN_WIDTH + LEVELS
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic signed [IN_WIDTH-1:0]  din [N],
    output logic signed [SUM_WIDTH-1:0] dout
);

    for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
        localparam int CNT  = (N + (1 << l) - 1) >> l;
        localparam int PREV = (l == 0) ? N : ((N << 1) + (1 << l) - 1) >> l;

        for (genvar i = 0; i < CNT; i++) begin : g_node
            logic signed [SUM_WIDTH-1:0] q;

            if (l == 0) begin : g_leaf
                assign q = SUM_WIDTH'(din[i]);
            end else if (2 * i + 1 < PREV) begin : g_sum
                always_ff @(posedge clk) begin
                    if (rst)
                        q <= '0;
                    else if (en)
                        q <= g_lvl[l-1].g_node[2*i].q + g_lvl[l-1].g_node[2*i+1].q;
                end
            end else begin : g_pass
                always_ff @(posedge clk) begin
                    if (rst)
                        q <= '0;
                    else if (en)
                        q <= g_lvl[l-1].g_node[2*i].q;
                end
            end
        end
    end

    assign dout = g_lvl[LEVELS].g_node[0].q;

endmodule

// File: rtl/filter_row.sv
// TAPS-wide 1-D convolution row with serial kernel load and valid/ready on both sides.
// Optional FILTER_ROW_SAT_EN: round-half-up shift and clamp to OUT_WIDTH in one extra stage.
module filter_row
    import filter_pkg::*;
#(
    parameter int IMG_WIDTH = 16,
    parameter int KER_WIDTH = 16,
    parameter int TAPS      = 3,
    parameter int OUT_WIDTH = 32,
    parameter int SHIFT     = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [KER_WIDTH-1:0] cfg_ker,
    input  logic                        cfg_val,
    output logic                        cfg_rdy,
    output logic                        cfg_done,
    input  logic signed [IMG_WIDTH-1:0] up_data,
    input  logic                        up_val,
    output logic                        up_rdy,
    output logic signed [OUT_WIDTH-1:0] dn_data,
    output logic                        dn_val,
    input  logic                        dn_rdy
);

    localparam int ACC_WIDTH  = acc_width(IMG_WIDTH, KER_WIDTH, TAPS);
    localparam int PROD_WIDTH = IMG_WIDTH + KER_WIDTH;
    localparam int LEVELS     = $clog2(TAPS);
    localparam int CNT_WIDTH  = $clog2(TAPS + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(TAPS);

    logic signed [KER_WIDTH-1:0]  ker [TAPS];
    logic signed [IMG_WIDTH-1:0]  win [TAPS];
    logic signed [PROD_WIDTH-1:0] prod [TAPS];
    logic signed [ACC_WIDTH-1:0]  acc;
    logic [CNT_WIDTH-1:0]         ld_cnt;
    logic [CNT_WIDTH-1:0]         fill_cnt;
    logic [CNT_WIDTH-1:0]         fill_next;
    logic [LEVELS-1:0]            tree_val;
    logic                         win_val;
    logic                         prod_val;
    logic                         en;
    logic                         up_acc;
    logic                         cfg_acc;
    logic                         issue;
    logic                         pipe_busy;

    assign en        = ~dn_val | dn_rdy;
    assign cfg_done  = (ld_cnt == CNT_FULL);
    assign up_rdy    = cfg_done & en;
    assign up_acc    = up_val & up_rdy;
    assign fill_next = (fill_cnt == CNT_FULL) ? CNT_FULL : fill_cnt + CNT_WIDTH'(1);
    assign issue     = up_acc & (fill_next == CNT_FULL);
    // Kernel swaps only with an empty pipeline so in-flight results never mix kernels.
    assign cfg_rdy   = ~pipe_busy & ~up_acc;
    assign cfg_acc   = cfg_val & cfg_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            ld_cnt   <= '0;
            fill_cnt <= '0;
            for (int i = 0; i < TAPS; i++)
                ker[i] <= '0;
        end else if (cfg_acc) begin
            ker[0] <= cfg_ker;
            for (int i = 1; i < TAPS; i++)
                ker[i] <= ker[i-1];
            if (cfg_done) begin
                ld_cnt   <= CNT_WIDTH'(1);
                fill_cnt <= '0;
            end else begin
                ld_cnt <= ld_cnt + CNT_WIDTH'(1);
            end
        end else if (up_acc) begin
            fill_cnt <= fill_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            win_val  <= 1'b0;
            prod_val <= 1'b0;
            tree_val <= '0;
            for (int i = 0; i < TAPS; i++) begin
                win[i]  <= '0;
                prod[i] <= '0;
            end
        end else if (en) begin
            if (up_acc) begin
                win[0] <= up_data;
                for (int i = 1; i < TAPS; i++)
                    win[i] <= win[i-1];
            end
            win_val <= issue;
            for (int i = 0; i < TAPS; i++)
                prod[i] <= PROD_WIDTH'(smul(MAX_W'(win[i]), MAX_W'(ker[i])));
            prod_val <= win_val;
            tree_val <= LEVELS'({tree_val, prod_val});
        end
    end

    filter_add_tree #(
        .N        (TAPS),
        .IN_WIDTH (PROD_WIDTH)
    ) u_tree (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .din  (prod),
        .dout (acc)
    );

`ifdef FILTER_ROW_SAT_EN
    localparam logic signed [ACC_WIDTH:0] RND     = ((ACC_WIDTH + 1)'(1) << SHIFT) >> 1;
    localparam logic signed [ACC_WIDTH:0] SAT_MAX = {{(ACC_WIDTH + 2 - OUT_WIDTH){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] SAT_MIN = {{(ACC_WIDTH + 2 - OUT_WIDTH){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

    logic signed [ACC_WIDTH:0]   sat_q;
    logic signed [OUT_WIDTH-1:0] sat_out;
    logic                        sat_val;

    assign pipe_busy = win_val | prod_val | (|tree_val) | sat_val | dn_val;

    always_comb begin
        sat_out = OUT_WIDTH'(sat_q);
        if (sat_q > SAT_MAX)
            sat_out = OUT_WIDTH'(SAT_MAX);
        else if (sat_q < SAT_MIN)
            sat_out = OUT_WIDTH'(SAT_MIN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sat_q   <= '0;
            sat_val <= 1'b0;
            dn_data <= '0;
            dn_val  <= 1'b0;
        end else if (en) begin
            sat_q   <= ((ACC_WIDTH + 1)'(acc) + RND) >>> SHIFT;
            sat_val <= tree_val[LEVELS-1];
            dn_data <= sat_out;
            dn_val  <= sat_val;
        end
    end
`else
    assign pipe_busy = win_val | prod_val | (|tree_val) | dn_val;

    always_ff @(posedge clk) begin
        if (rst) begin
            dn_data <= '0;
            dn_val  <= 1'b0;
        end else if (en) begin
            dn_data <= OUT_WIDTH'(acc >>> SHIFT);
            dn_val  <= tree_val[LEVELS-1];
        end
    end
`endif

endmodule

// File: tb/tb_filter_row.sv
// Directed bench for filter_row: a full-width instance plus a SHIFT=2, 8-bit output
// instance sharing the same stimulus.
`timescale 1ns/1ps
module tb_filter_row;

    localparam int IW   = 8;
    localparam int KW   = 8;
    localparam int TAPS = 3;
    localparam int OW   = 18;
    localparam int OWS  = 8;
`ifdef FILTER_ROW_SAT_EN
    localparam int XLAT = 5;
    localparam bit SAT  = 1'b1;
`else
    localparam int XLAT = 4;
    localparam bit SAT  = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst;
    logic signed [KW-1:0]  cfg_ker;
    logic                  cfg_val;
    logic                  cfg_rdy, cfg_done, cfg_rdy_s, cfg_done_s;
    logic signed [IW-1:0]  up_data;
    logic                  up_val;
    logic                  up_rdy, up_rdy_s;
    logic signed [OW-1:0]  dn_data;
    logic signed [OWS-1:0] dn_data_s;
    logic                  dn_val, dn_val_s;
    logic                  dn_rdy;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    filter_row #(.IMG_WIDTH(IW), .KER_WIDTH(KW), .TAPS(TAPS), .OUT_WIDTH(OW), .SHIFT(0)) dut (
        .clk(clk), .rst(rst), .cfg_ker(cfg_ker), .cfg_val(cfg_val), .cfg_rdy(cfg_rdy),
        .cfg_done(cfg_done), .up_data(up_data), .up_val(up_val), .up_rdy(up_rdy),
        .dn_data(dn_data), .dn_val(dn_val), .dn_rdy(dn_rdy)
    );

    filter_row #(.IMG_WIDTH(IW), .KER_WIDTH(KW), .TAPS(TAPS), .OUT_WIDTH(OWS), .SHIFT(2)) dut_s (
        .clk(clk), .rst(rst), .cfg_ker(cfg_ker), .cfg_val(cfg_val), .cfg_rdy(cfg_rdy_s),
        .cfg_done(cfg_done_s), .up_data(up_data), .up_val(up_val), .up_rdy(up_rdy_s),
        .dn_data(dn_data_s), .dn_val(dn_val_s), .dn_rdy(dn_rdy)
    );

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int k);
        check("load_cfg_rdy", cfg_rdy, 1);
        cfg_ker = KW'(k);
        cfg_val = 1'b1;
        step();
        cfg_val = 1'b0;
    endtask

    task automatic push(input int x);
        int t;
        t = 0;
        up_data = IW'(x);
        up_val  = 1'b1;
        while (!up_rdy && t < 200) begin
            step();
            t++;
        end
        check("push_up_rdy", up_rdy, 1);
        step();
        up_val = 1'b0;
    endtask

    task automatic wait_dv(input int budget);
        int t;
        t = 0;
        while (!dn_val && t < budget) begin
            step();
            t++;
        end
        check("wait_dn_val", dn_val, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int kq[3];
        logic signed [IW-1:0] hist[$];
        logic signed [63:0] exp_q[$];
        logic signed [63:0] e;
        logic signed [OW-1:0] hold;
        bit stalled;
        int sent, got, cyc;

        rst = 1'b1; cfg_val = 1'b0; cfg_ker = '0; up_val = 1'b0; up_data = '0; dn_rdy = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();

        // reset state
        check("rst_dn_val", dn_val, 0);
        check("rst_dn_data", dn_data, 0);
        check("rst_cfg_done", cfg_done, 0);
        check("rst_cfg_rdy", cfg_rdy, 1);
        check("rst_up_rdy", up_rdy, 0);
        check("rst_s_dn_val", dn_val_s, 0);
        check("rst_s_cfg_done", cfg_done_s, 0);
        check("rst_s_cfg_rdy", cfg_rdy_s, 1);
        check("rst_s_up_rdy", up_rdy_s, 0);

        // kernel 1,2,3 then stream 1..4, latency and fill
        load(1);
        check("ld1_done", cfg_done, 0);
        load(2);
        check("ld2_done", cfg_done, 0);
        load(3);
        check("ld3_done", cfg_done, 1);
        check("ld3_up_rdy", up_rdy, 1);
        for (int j = 1; j <= 4; j++) begin
            up_data = IW'(j);
            up_val  = 1'b1;
            check("stream_up_rdy", up_rdy, 1);
            step();
            check("early_dn_val", dn_val, 0);
        end
        up_val = 1'b0;
        for (int j = 2; j < XLAT; j++) begin
            step();
            check("lat_dn_val", dn_val, 0);
        end
        step();
        check("first_dn_val", dn_val, 1);
        check("first_dn_data", dn_data, 14);
        check("first_s_data", dn_data_s, SAT ? 4 : 3);
        step();
        check("second_dn_val", dn_val, 1);
        check("second_dn_data", dn_data, 20);
        check("second_s_data", dn_data_s, 5);
        step();
        check("drained_dn_val", dn_val, 0);

        // extreme sums
        load(-128); load(-128); load(-128);
        push(-128); push(-128); push(-128);
        wait_dv(20);
        check("max_pos_data", dn_data, 49152);
        check("max_pos_s_data", dn_data_s, SAT ? 127 : 0);
        step();
        load(127); load(127); load(127);
        push(-128); push(-128); push(-128);
        wait_dv(20);
        check("max_neg_data", dn_data, -48768);
        check("max_neg_s_data", dn_data_s, SAT ? -128 : 96);
        step();

        // cfg_val while busy is ignored; stalled output holds
        load(1); load(2); load(3);
        dn_rdy = 1'b0;
        push(5); push(6); push(7);
        wait_dv(20);
        check("stall_data", dn_data, 38);
        check("busy_cfg_rdy", cfg_rdy, 0);
        cfg_ker = KW'(99);
        cfg_val = 1'b1;
        step();
        cfg_val = 1'b0;
        check("ignored_cfg_done", cfg_done, 1);
        check("hold_dn_val", dn_val, 1);
        check("hold_dn_data", dn_data, 38);
        check("stall_up_rdy", up_rdy, 0);
        dn_rdy = 1'b1;
        step();
        check("consumed_dn_val", dn_val, 0);

        // new kernel restarts the fill
        load(1); load(1); load(1);
        check("reload_done", cfg_done, 1);
        push(10); push(20);
        for (int j = 0; j <= XLAT; j++) begin
            check("refill_dn_val", dn_val, 0);
            step();
        end
        push(30);
        wait_dv(20);
        check("refill_data", dn_data, 60);
        step();

        // reset while stalled with valid output
        dn_rdy = 1'b0;
        push(40);
        wait_dv(20);
        check("pre_rst_data", dn_data, 90);
        rst = 1'b1;
        step();
        check("mid_rst_dn_val", dn_val, 0);
        check("mid_rst_cfg_done", cfg_done, 0);
        check("mid_rst_up_rdy", up_rdy, 0);
        check("mid_rst_dn_data", dn_data, 0);
        check("mid_rst_cfg_rdy", cfg_rdy, 1);
        rst = 1'b0;
        dn_rdy = 1'b1;
        step();

        // random backpressure against a window model
        kq = '{1, 2, 3};
        load(kq[0]); load(kq[1]); load(kq[2]);
        sent = 0; got = 0; cyc = 0; stalled = 1'b0; hold = '0;
        while (got < 98 && cyc < 3000) begin
            if (stalled) begin
                check("rand_hold_val", dn_val, 1);
                check("rand_hold_data", dn_data, hold);
            end
            dn_rdy = 1'($urandom_range(0, 1));
            up_val = (sent < 100) ? 1'($urandom_range(0, 1)) : 1'b0;
            up_data = IW'(sent);
            #1;
            if (dn_val && !dn_rdy)
                check("rand_full_up_rdy", up_rdy, 0);
            if (dn_val && dn_rdy) begin
                if (exp_q.size() == 0) begin
                    check("rand_unexpected", dn_val, 0);
                end else begin
                    check("rand_data", dn_data, exp_q.pop_front());
                end
                got++;
            end
            if (up_val && up_rdy) begin
                hist.push_back(up_data);
                if (hist.size() >= 3) begin
                    e = 0;
                    for (int j = 0; j < 3; j++)
                        e += kq[j] * hist[hist.size() - 3 + j];
                    exp_q.push_back(e);
                end
                sent++;
            end
            stalled = dn_val && !dn_rdy;
            hold = dn_data;
            step();
            cyc++;
        end
        up_val = 1'b0;
        check("rand_count", got, 98);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
